// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard receiver types: scan-code prefixes, decoder states, key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: sync, falling-edge sample of 11-bit frame, parity/stop check; byte_valid/frame_err one cycle after stop edge.
// Define PS2_KBD_TIMEOUT_EN to abort partial frames after TIMEOUT cycles without a clock edge.
module ps2_rx_frame #(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  logic       clk_s1_q, clk_s2_q, clk_prev_q;
  logic       dat_s1_q, dat_s2_q;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] byte_q, byte_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;
  logic       fall;

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    fall         = clk_prev_q & ~clk_s2_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall) begin
      case (bit_cnt_q)
        4'd0: if (!dat_s2_q) bit_cnt_d = 4'd1;
        4'd9: begin
          par_d     = dat_s2_q;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (dat_s2_q && ((^shift_q) ^ par_q)) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end
`ifdef PS2_KBD_TIMEOUT_EN
    to_cnt_d = '0;
    if (!fall && bit_cnt_q != 4'd0) begin
      if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
        bit_cnt_d   = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef PS2_KBD_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= ps2_data;
      dat_s2_q     <= dat_s1_q;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef PS2_KBD_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: E0/F0 prefix decoder feeding a key-event FIFO with valid/ready output.
// Event visible 2 cycles after stop edge detect; full FIFO drops new events and sets sticky overflow.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       rx_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic       byte_valid, frame_err;
  logic [7:0] rx_byte;

  ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_frame (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_kbd_clk),
    .ps2_data   (ps2_kbd_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  dec_state_t state_q, state_d;
  logic       push;
  key_event_t push_evt;

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_err) begin
      state_d = IDLE;
    end else if (byte_valid) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        state_d = (state_q == GOT_F0 || state_q == GOT_E0F0) ? GOT_E0F0 : GOT_E0;
      end else if (rx_byte == PS2_PREFIX_REL) begin
        state_d = (state_q == GOT_E0 || state_q == GOT_E0F0) ? GOT_E0F0 : GOT_F0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    push          = byte_valid && rx_byte != PS2_PREFIX_EXT && rx_byte != PS2_PREFIX_REL;
    push_evt.ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
    push_evt.rel  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
    push_evt.code = rx_byte;
  end

  key_event_t      mem_q [FIFO_DEPTH];
  key_event_t      mem_d [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  key_event_t      head_q, head_d;
  logic            empty, full, pop, wr_en;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop   = !empty && key_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr_en = push && (!full || pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = push_evt;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ovf_d    = ovf_q | (push & full & ~pop);
    head_d   = empty ? head_q : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  assign key_valid   = !empty;
  assign key_code    = head_d.code;
  assign key_ext     = head_d.ext;
  assign key_release = head_d.rel;
  assign rx_err      = frame_err;
  assign overflow    = ovf_q;

endmodule
